// File: rtl/exa_crosb_mux_arbiter.sv
// exa_crosb_mux_arbiter: crossbar output merge with packet lock and round-robin.
// Optional EXA_CROSB_MUX_PRIO_EN: high-priority requests take precedence.
module exa_crosb_mux_arbiter #(
    parameter int data_width = 128,
    parameter int input_num  = 16,
    localparam int sel_width = $clog2(input_num)
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [input_num*data_width-1:0] DATA_i,
    input  logic [input_num-1:0]            VALID_i,
    input  logic [input_num-1:0]            LAST_i,
    input  logic [input_num-1:0]            PRIO_i,
    output logic [input_num-1:0]            READY_o,
    output logic [data_width-1:0]           DATA_o,
    output logic                            VALID_o,
    output logic                            LAST_o,
    output logic                            PRIO_o,
    input  logic                            READY_i,
    output logic [sel_width-1:0]            OWNER_o,
    output logic                            BUSY_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [sel_width-1:0] rr_ptr;
    logic [sel_width-1:0] owner;
    logic                 prio_q;
    logic [input_num-1:0] req;
    logic [sel_width-1:0] winner;
    logic                 any_req;
    logic                 out_free;
    logic                 xfer;
    logic [data_width-1:0] din [input_num];

    for (genvar g = 0; g < input_num; g++) begin : g_din
        assign din[g] = DATA_i[g*data_width +: data_width];
    end

    assign out_free = !VALID_o || READY_i;
    assign xfer     = (state == LOCKED) && VALID_i[owner] && out_free;
    assign OWNER_o  = owner;
    assign BUSY_o   = (state == LOCKED);

    // Request vector, optionally restricted to the high-priority class
`ifdef EXA_CROSB_MUX_PRIO_EN
    always_comb begin
        if (|(VALID_i & PRIO_i))
            req = VALID_i & PRIO_i;
        else
            req = VALID_i;
    end
`else
    always_comb begin
        req = VALID_i;
    end
`endif

    // Round-robin search: first request at or after rr_ptr, wrapping
    always_comb begin
        int                   idx;
        logic [sel_width-1:0] cand;
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        cand    = '0;
        for (int i = input_num - 1; i >= 0; i--) begin
            idx  = (int'(rr_ptr) + i) % input_num;
            cand = sel_width'(idx);
            if (req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    // Clear-to-send goes only to the lock owner, gated by output space
    always_comb begin
        READY_o = '0;
        if (state == LOCKED)
            READY_o[owner] = out_free;
    end

    // Lock FSM, round-robin pointer and output beat register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            prio_q  <= 1'b0;
            DATA_o  <= '0;
            VALID_o <= 1'b0;
            LAST_o  <= 1'b0;
            PRIO_o  <= 1'b0;
        end else begin
            if (xfer) begin
                DATA_o  <= din[owner];
                LAST_o  <= LAST_i[owner];
                PRIO_o  <= prio_q;
                VALID_o <= 1'b1;
            end else if (READY_i && VALID_o) begin
                VALID_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= winner;
                        prio_q <= PRIO_i[winner];
                        state  <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer && LAST_i[owner]) begin
                        state <= IDLE;
                        if (owner == sel_width'(input_num - 1))
                            rr_ptr <= '0;
                        else
                            rr_ptr <= owner + sel_width'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exa_crosb_mux_arbiter.sv
// tb_exa_crosb_mux_arbiter: directed table-driven bench for the merge arbiter.
// Builds its expectations from hand-computed cycle tables.
module tb_exa_crosb_mux_arbiter;

    localparam int DW = 128;
    localparam int N  = 16;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [N*DW-1:0] DATA_i;
    logic [N-1:0]    VALID_i;
    logic [N-1:0]    LAST_i;
    logic [N-1:0]    PRIO_i;
    logic [N-1:0]    READY_o;
    logic [DW-1:0]   DATA_o;
    logic            VALID_o;
    logic            LAST_o;
    logic            PRIO_o;
    logic            READY_i;
    logic [3:0]      OWNER_o;
    logic            BUSY_o;

    exa_crosb_mux_arbiter #(.data_width(DW), .input_num(N)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .DATA_i  (DATA_i),
        .VALID_i (VALID_i),
        .LAST_i  (LAST_i),
        .PRIO_i  (PRIO_i),
        .READY_o (READY_o),
        .DATA_o  (DATA_o),
        .VALID_o (VALID_o),
        .LAST_o  (LAST_o),
        .PRIO_o  (PRIO_o),
        .READY_i (READY_i),
        .OWNER_o (OWNER_o),
        .BUSY_o  (BUSY_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [15:0] v;
        logic [15:0] l;
        logic [15:0] p;
        logic        rdy;
        logic [7:0]  tag;
        logic [15:0] e_rdy;
        logic        e_val;
        logic        e_last;
        logic        e_prio;
        logic        e_busy;
        logic [3:0]  e_own;
        logic [15:0] e_data;
    } step_t;

    step_t tbl[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [15:0] b(input int n);
        return 16'(1) << n;
    endfunction

    function automatic step_t mk(
        input logic [15:0] v, l, p, input logic rdy, input logic [7:0] tag,
        input logic [15:0] erdy, input logic ev, el, ep, eb,
        input int eown, input logic [15:0] edata);
        step_t s;
        s.v = v; s.l = l; s.p = p; s.rdy = rdy; s.tag = tag;
        s.e_rdy = erdy; s.e_val = ev; s.e_last = el; s.e_prio = ep;
        s.e_busy = eb; s.e_own = 4'(eown); s.e_data = edata;
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, l, p, input logic rdy,
                         input logic [7:0] tag);
        VALID_i = v;
        LAST_i  = l;
        PRIO_i  = p;
        READY_i = rdy;
        for (int i = 0; i < N; i++)
            DATA_i[i*DW +: DW] = {112'b0, 8'(i), tag};
    endtask

    task automatic run(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            step_t s;
            s = tbl[k];
            @(posedge ACLK); #1;
            drive(s.v, s.l, s.p, s.rdy, s.tag);
            @(negedge ACLK);
            chk($sformatf("s%0d ready_o", k), 128'(READY_o), 128'(s.e_rdy));
            chk($sformatf("s%0d valid_o", k), 128'(VALID_o), 128'(s.e_val));
            chk($sformatf("s%0d busy_o", k), 128'(BUSY_o), 128'(s.e_busy));
            chk($sformatf("s%0d prio_o", k), 128'(PRIO_o), 128'(s.e_prio));
            if (s.e_busy)
                chk($sformatf("s%0d owner_o", k), 128'(OWNER_o), 128'(s.e_own));
            if (s.e_val) begin
                chk($sformatf("s%0d data_o", k), 128'(DATA_o), 128'(s.e_data));
                chk($sformatf("s%0d last_o", k), 128'(LAST_o), 128'(s.e_last));
            end
        end
    endtask

    task automatic chk_zero(input string tagn);
        chk({tagn, " ready_o"}, 128'(READY_o), 128'(0));
        chk({tagn, " data_o"}, 128'(DATA_o), 128'(0));
        chk({tagn, " valid_o"}, 128'(VALID_o), 128'(0));
        chk({tagn, " last_o"}, 128'(LAST_o), 128'(0));
        chk({tagn, " prio_o"}, 128'(PRIO_o), 128'(0));
        chk({tagn, " owner_o"}, 128'(OWNER_o), 128'(0));
        chk({tagn, " busy_o"}, 128'(BUSY_o), 128'(0));
    endtask

    initial begin
        int          w;
        logic [15:0] vb;
        logic [15:0] hi;
`ifdef EXA_CROSB_MUX_PRIO_EN
        w = 9;
`else
        w = 2;
`endif
        vb = b(0) | b(5) | b(15);
        hi = 16'hFFFF;

        // A: 4-beat packet on input 3
        tbl.push_back(mk(b(3), 0, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(b(3), 0, 0, 1, 8'h11, b(3), 0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(b(3), 0, 0, 1, 8'h12, b(3), 1, 0, 0, 1, 3, 16'h0311));
        tbl.push_back(mk(b(3), 0, 0, 1, 8'h13, b(3), 1, 0, 0, 1, 3, 16'h0312));
        tbl.push_back(mk(b(3), b(3), 0, 1, 8'h14, b(3), 1, 0, 0, 1, 3, 16'h0313));
        tbl.push_back(mk(0, 0, 0, 1, 8'h15, 0, 1, 1, 0, 0, 0, 16'h0314));
        tbl.push_back(mk(0, 0, 0, 1, 8'h16, 0, 0, 0, 0, 0, 0, 0));
        // A: 3-beat packet on input 6 under READY_i 1,0,0,1
        tbl.push_back(mk(b(6), 0, b(6), 1, 8'h20, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(b(6), 0, b(6), 1, 8'h21, b(6), 0, 0, 0, 1, 6, 0));
        tbl.push_back(mk(b(6), 0, b(6), 0, 8'h22, 0, 1, 0, 1, 1, 6, 16'h0621));
        tbl.push_back(mk(b(6), 0, b(6), 0, 8'h23, 0, 1, 0, 1, 1, 6, 16'h0621));
        tbl.push_back(mk(b(6), 0, b(6), 1, 8'h24, b(6), 1, 0, 1, 1, 6, 16'h0621));
        tbl.push_back(mk(b(6), b(6), b(6), 1, 8'h25, b(6), 1, 0, 1, 1, 6, 16'h0624));
        tbl.push_back(mk(0, 0, 0, 1, 8'h26, 0, 1, 1, 1, 0, 0, 16'h0625));
        tbl.push_back(mk(0, 0, 0, 1, 8'h27, 0, 0, 0, 1, 0, 0, 0));
        // A: owner 10 stalls while input 1 waits, then input 1 wraps in
        tbl.push_back(mk(b(10) | b(1), 0, 0, 1, 8'h30, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(b(10) | b(1), 0, 0, 1, 8'h31, b(10), 0, 0, 1, 1, 10, 0));
        tbl.push_back(mk(b(1), 0, 0, 1, 8'h32, b(10), 1, 0, 0, 1, 10, 16'h0A31));
        tbl.push_back(mk(b(1), 0, 0, 1, 8'h33, b(10), 0, 0, 0, 1, 10, 0));
        tbl.push_back(mk(b(1), 0, 0, 1, 8'h34, b(10), 0, 0, 0, 1, 10, 0));
        tbl.push_back(mk(b(10) | b(1), b(10), 0, 1, 8'h35, b(10), 0, 0, 0, 1, 10, 0));
        tbl.push_back(mk(b(1), 0, 0, 1, 8'h36, 0, 1, 1, 0, 0, 0, 16'h0A35));
        tbl.push_back(mk(b(1), b(1), 0, 1, 8'h37, b(1), 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h38, 0, 1, 1, 0, 0, 0, 16'h0137));
        tbl.push_back(mk(0, 0, 0, 1, 8'h39, 0, 0, 0, 0, 0, 0, 0));
        // B (index 25): inputs 0, 5, 15 with 2-beat packets from rr_ptr 0
        tbl.push_back(mk(vb, 0, 0, 1, 8'h40, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h41, b(0), 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(vb, hi, 0, 1, 8'h42, b(0), 1, 0, 0, 1, 0, 16'h0041));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h43, 0, 1, 1, 0, 0, 0, 16'h0042));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h44, b(5), 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(vb, hi, 0, 1, 8'h45, b(5), 1, 0, 0, 1, 5, 16'h0544));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h46, 0, 1, 1, 0, 0, 0, 16'h0545));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h47, b(15), 0, 0, 0, 1, 15, 0));
        tbl.push_back(mk(vb, hi, 0, 1, 8'h48, b(15), 1, 0, 0, 1, 15, 16'h0F47));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h49, 0, 1, 1, 0, 0, 0, 16'h0F48));
        tbl.push_back(mk(vb, 0, 0, 1, 8'h4A, b(0), 0, 0, 0, 1, 0, 0));
        // C (index 36): input 2 low vs input 9 high priority, rr_ptr 0
        tbl.push_back(mk(b(2) | b(9), 0, b(9), 1, 8'h50, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(b(2) | b(9), hi, b(9), 1, 8'h51, b(w), 0, 0, 0, 1, w, 0));
        tbl.push_back(mk(0, 0, b(9), 1, 8'h52, 0, 1, 1, (w == 9), 0, 0,
                         {8'(w), 8'h51}));

        ARESETN = 1'b0;
        drive(0, 0, 0, 1, 8'h00);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_zero("reset");
        ARESETN = 1'b1;

        run(0, 24);

        // Mid-packet async reset on input 4
        @(posedge ACLK); #1;
        drive(b(4), 0, 0, 1, 8'h60);
        @(posedge ACLK); #1;
        drive(b(4), 0, 0, 1, 8'h61);
        @(posedge ACLK); #1;
        drive(b(4), 0, 0, 1, 8'h62);
        chk("pre-rst busy_o", 128'(BUSY_o), 128'(1));
        chk("pre-rst valid_o", 128'(VALID_o), 128'(1));
        chk("pre-rst owner_o", 128'(OWNER_o), 128'(4));
        #2;
        ARESETN = 1'b0;
        #1;
        chk_zero("async-rst");
        @(negedge ACLK);
        drive(0, 0, 0, 1, 8'h00);
        ARESETN = 1'b1;

        run(25, 35);

        @(negedge ACLK);
        drive(0, 0, 0, 1, 8'h00);
        ARESETN = 1'b0;
        #2;
        ARESETN = 1'b1;

        run(36, 38);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
